// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous threshold FIFO family.
package fifo_pkg;

  localparam int FIFO_DP_MAX = 256;

  // Bits needed to hold a count in 0..dp inclusive.
  function automatic int fifo_cnt_w(input int dp);
    return $clog2(dp + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_th_mem.sv
// W x DP storage for sync_fifo_th: one synchronous write port, one asynchronous read port.
// Kept separate so it can be replaced by an SRAM macro wrapper.
module sync_fifo_th_mem #(
  parameter int W  = 8,
  parameter int DP = 4,
  parameter int AW = $clog2(DP)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DP];

  // No reset: contents are only observable after being written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO, any depth 2..256, programmable almost-full/empty, flush, sticky errors.
// Optional high-water mark enabled by defining SYNC_FIFO_TH_PEAK_EN.
module sync_fifo_th
  import fifo_pkg::*;
#(
  parameter int W  = 8,
  parameter int DP = 4,
  parameter int AW = $clog2(DP),
  parameter int CW = fifo_cnt_w(DP)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [CW-1:0] cfg_afull_th,
  input  logic [CW-1:0] cfg_aempty_th,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  output logic          afull,
  output logic [CW-1:0] wr_free_cnt,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          aempty,
  output logic [CW-1:0] rd_aval_cnt,
  input  logic          err_clr,
  output logic          ovf_err,
  output logic          udf_err,
  input  logic          peak_clr,
  output logic [CW-1:0] peak_level
);

  if (DP < 2 || DP > FIFO_DP_MAX) begin : g_bad_dp
    $error("sync_fifo_th: DP out of range");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  // Full with a simultaneous read frees a slot in the same cycle, so the write is taken.
  assign wr_acc = wr_en & (~full | rd_en) & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == AW'(DP - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == AW'(DP - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        level_d = level_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        level_d = level_q - CW'(1);
      end
    end
  end

  // A new error in the same cycle as err_clr must not be lost.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && !wr_acc && !flush) begin
      ovf_d = 1'b1;
    end
    if (rd_en && empty && !flush) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign full        = (level_q == CW'(DP));
  assign empty       = (level_q == '0);
  assign afull       = (level_q >= cfg_afull_th);
  assign aempty      = (level_q <= cfg_aempty_th);
  assign wr_free_cnt = CW'(DP) - level_q;
  assign rd_aval_cnt = level_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

`ifdef SYNC_FIFO_TH_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = level_d;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_level = peak_q;
`else
  // Masking with peak_clr keeps the otherwise-ignored input connected; result is always 0.
  assign peak_level = {CW{1'b0}} & {CW{peak_clr}};
`endif

  sync_fifo_th_mem #(
    .W  (W),
    .DP (DP),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_th.sv
// Scoreboard bench for sync_fifo_th (DP=5, W=8): directed scenarios then random traffic.
// Peak expectations follow SYNC_FIFO_TH_PEAK_EN when defined.
module tb_sync_fifo_th;

  localparam int W  = 8;
  localparam int DP = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [CW-1:0] cfg_afull_th;
  logic [CW-1:0] cfg_aempty_th;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          full, afull, empty, aempty;
  logic [CW-1:0] wr_free_cnt, rd_aval_cnt, peak_level;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          err_clr, ovf_err, udf_err, peak_clr;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue, everything else derived from its size.
  logic [W-1:0] mdl_q[$];
  logic [W-1:0] sb_q[$];
  bit           m_ovf, m_udf;
  int           m_peak;

  always #5 clk = ~clk;

  sync_fifo_th #(.W(W), .DP(DP)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .cfg_afull_th  (cfg_afull_th),
    .cfg_aempty_th (cfg_aempty_th),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .afull         (afull),
    .wr_free_cnt   (wr_free_cnt),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .aempty        (aempty),
    .rd_aval_cnt   (rd_aval_cnt),
    .err_clr       (err_clr),
    .ovf_err       (ovf_err),
    .udf_err       (udf_err),
    .peak_clr      (peak_clr),
    .peak_level    (peak_level)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int exp_peak();
`ifdef SYNC_FIFO_TH_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    int lvl;
    lvl = mdl_q.size();
    chk("full",        int'(full),        int'(lvl == DP));
    chk("empty",       int'(empty),       int'(lvl == 0));
    chk("afull",       int'(afull),       int'(lvl >= int'(cfg_afull_th)));
    chk("aempty",      int'(aempty),      int'(lvl <= int'(cfg_aempty_th)));
    chk("wr_free_cnt", int'(wr_free_cnt), DP - lvl);
    chk("rd_aval_cnt", int'(rd_aval_cnt), lvl);
    chk("ovf_err",     int'(ovf_err),     int'(m_ovf));
    chk("udf_err",     int'(udf_err),     int'(m_udf));
    chk("peak_level",  int'(peak_level),  exp_peak());
    if (lvl != 0) chk("rd_data_head", int'(rd_data), int'(mdl_q[0]));
  endtask

  // Monitor: every DUT-visible pop is compared against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (reset_n && rd_en && !flush && !empty) begin
      if (sb_q.size() == 0) begin
        chk("pop_unexpected", int'(rd_data), -1);
      end else begin
        logic [W-1:0] e;
        e = sb_q.pop_front();
        chk("pop_data", int'(rd_data), int'(e));
        $display("read  data=0x%02h expect=0x%02h", rd_data, e);
      end
    end
  end

  task automatic model_reset();
    mdl_q.delete();
    sb_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_peak = 0;
  endtask

  task automatic model_update(input bit we, input logic [W-1:0] wd, input bit re,
                              input bit fl, input bit ec, input bit pc);
    bit is_full, is_empty, wa, ra;
    is_full  = (mdl_q.size() == DP);
    is_empty = (mdl_q.size() == 0);
    if (ec) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (fl) begin
      mdl_q.delete();
      sb_q.delete();
    end else begin
      wa = we && (!is_full || re);
      ra = re && !is_empty;
      if (we && !wa) m_ovf = 1'b1;
      if (re && is_empty) m_udf = 1'b1;
      if (ra) void'(mdl_q.pop_front());
      if (wa) begin
        mdl_q.push_back(wd);
        sb_q.push_back(wd);
      end
    end
    if (pc) m_peak = mdl_q.size();
    else if (mdl_q.size() > m_peak) m_peak = mdl_q.size();
  endtask

  task automatic step(input bit we, input logic [W-1:0] wd, input bit re,
                      input bit fl = 0, input bit ec = 0, input bit pc = 0);
    wr_en = we; wr_data = wd; rd_en = re; flush = fl; err_clr = ec; peak_clr = pc;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update(we, wd, re, fl, ec, pc);
    #1;
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; peak_clr = 0;
    if (we) $display("cycle wr=0x%02h rd=%0d flush=%0d level=%0d", wd, re, fl, mdl_q.size());
  endtask

  task automatic idle();
    step(0, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    err_clr = 0; peak_clr = 0;
    cfg_afull_th = 3'd4; cfg_aempty_th = 3'd1;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk); #1;
    reset_n = 1;

    // Fill, overflow, drain in order.
    for (int i = 0; i < DP; i++) step(1, 8'(8'h11 + i), 0);
    step(1, 8'h16, 0);
    for (int i = 0; i < DP; i++) step(0, '0, 1);
    step(0, '0, 0, 0, 1);

    // Full with concurrent read/write across pointer wrap.
    for (int i = 0; i < DP; i++) step(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 12; i++) step(1, 8'(8'h40 + i), 1);
    for (int i = 0; i < DP; i++) step(0, '0, 1);

    // Underflow with simultaneous write; set beats clear.
    step(1, 8'hA5, 1);
    idle();
    step(0, '0, 1);
    step(0, '0, 1, 0, 1);
    idle();
    step(0, '0, 0, 0, 1);

    // Threshold edges.
    cfg_afull_th = 3'd3; cfg_aempty_th = 3'd1;
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0);
    idle();
    cfg_afull_th = 3'd0; cfg_aempty_th = 3'd5;
    idle();
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    cfg_afull_th = 3'd4; cfg_aempty_th = 3'd1;

    // Flush overrides write; errors retained.
    step(0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0);
    step(1, 8'h7F, 0, 1);
    idle();

    // Asynchronous reset mid-burst.
    step(1, 8'h81, 0);
    step(1, 8'h82, 0);
    wr_en = 1; wr_data = 8'h83;
    reset_n = 0;
    #1;
    chk("rst_empty",   int'(empty), 1);
    chk("rst_full",    int'(full), 0);
    chk("rst_free",    int'(wr_free_cnt), DP);
    chk("rst_aval",    int'(rd_aval_cnt), 0);
    chk("rst_udf",     int'(udf_err), 0);
    chk("rst_peak",    int'(peak_level), 0);
    model_reset();
    wr_en = 0;
    @(posedge clk); #1;
    reset_n = 1;

    // High-water mark.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h90 + i), 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    step(1, 8'h99, 0);
    step(1, 8'h9A, 0, 0, 0, 1);
    idle();
    for (int i = 0; i < 2; i++) step(0, '0, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_afull_th  = CW'($urandom_range(0, DP));
        cfg_aempty_th = CW'($urandom_range(0, 7));
      end
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
           $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
